mc_control_g7: RTL and testbench

//  Multicycle RISC-V control FSM: the producer side of the ALU interface (ALUControl out, zero in).

---
 rtl/mc_control_g7_pkg.sv | 54 +++++
 rtl/mc_control_g7_alu_decoder.sv | 39 +++
 rtl/mc_control_g7.sv | 170 +++++++++++++++++
 tb/tb_mc_control_g7.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_control_g7_pkg.sv
// Shared encodings for the multicycle RISC-V control slice: states, opcodes,
// ALU control codes, ALUOp codes and datapath mux selects.
package mc_control_g7_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10,
      S_HALT     = 4'd11
   } state_t;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_SRL = 4'b0100;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/mc_control_g7_alu_decoder.sv
// Combinational ALU decoder: ALUOp plus instruction function fields -> ALUControl.
// alu_illegal flags function fields that have no ALU operation, independent of ALUOp.
module alu_decoder_g7
   import mc_control_g7_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [2:0] funct3,
   input  logic       op5,
   input  logic       funct7b5,
   output logic [3:0] alu_control,
   output logic       alu_illegal
);

   logic [3:0] funct_ctrl;

   always_comb begin
      funct_ctrl  = ALU_ADD;
      alu_illegal = 1'b0;
      case (funct3)
         3'b000:  funct_ctrl = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
         3'b111:  funct_ctrl = ALU_AND;
         3'b110:  funct_ctrl = ALU_OR;
         3'b101: begin
            funct_ctrl  = ALU_SRL;
            alu_illegal = funct7b5;
         end
         default: alu_illegal = 1'b1;
      endcase
   end

   always_comb begin
      case (alu_op)
         ALUOP_SUB:   alu_control = ALU_SUB;
         ALUOP_FUNCT: alu_control = funct_ctrl;
         default:     alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_control_g7.sv
// Multicycle RISC-V control FSM (fetch/decode/execute/memory/writeback).
// Optional macro G7_BNE_EN makes bne (branch funct3=001) legal.
module mc_control_g7
   import mc_control_g7_pkg::*;
#(
   parameter bit ILLEGAL_HALT = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic       RegWrite,
   output logic [3:0] ALUControl,
   output logic       illegal,
   output logic [3:0] state_o
);

   state_t     state, next_state;
   logic [1:0] alu_op;
   logic       funct_illegal;
   logic       decode_illegal;
   logic       branch_take;

   alu_decoder_g7 u_alu_dec (
      .alu_op      (alu_op),
      .funct3      (funct3),
      .op5         (op[5]),
      .funct7b5    (funct7b5),
      .alu_control (ALUControl),
      .alu_illegal (funct_illegal)
   );

   always_comb begin
      case (op)
         OP_LW, OP_SW: decode_illegal = (funct3 != 3'b010);
         OP_R, OP_I:   decode_illegal = funct_illegal;
`ifdef G7_BNE_EN
         OP_BR:        decode_illegal = (funct3 != 3'b000) && (funct3 != 3'b001);
`else
         OP_BR:        decode_illegal = (funct3 != 3'b000);
`endif
         OP_JAL:       decode_illegal = 1'b0;
         default:      decode_illegal = 1'b1;
      endcase
   end

`ifdef G7_BNE_EN
   assign branch_take = funct3[0] ? ~zero : zero;
`else
   assign branch_take = zero;
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= S_FETCH;
      else       state <= next_state;
   end

   always_comb begin
      next_state = S_FETCH;
      case (state)
         S_FETCH:  next_state = S_DECODE;
         S_DECODE: begin
            if (decode_illegal)
               next_state = ILLEGAL_HALT ? S_HALT : S_FETCH;
            else begin
               case (op)
                  OP_LW, OP_SW: next_state = S_MEMADR;
                  OP_R:         next_state = S_EXECUTER;
                  OP_I:         next_state = S_EXECUTEI;
                  OP_BR:        next_state = S_BEQ;
                  OP_JAL:       next_state = S_JAL;
                  default:      next_state = S_FETCH;
               endcase
            end
         end
         S_MEMADR:   next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  next_state = S_MEMWB;
         S_EXECUTER: next_state = S_ALUWB;
         S_EXECUTEI: next_state = S_ALUWB;
         S_JAL:      next_state = S_ALUWB;
         S_HALT:     next_state = S_HALT;
         default:    next_state = S_FETCH;
      endcase
   end

   always_comb begin
      PCWrite   = 1'b0;
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      ResultSrc = RES_ALUOUT;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_RS2;
      ImmSrc    = IMM_I;
      alu_op    = ALUOP_ADD;
      illegal   = 1'b0;
      case (state)
         S_FETCH: begin
            IRWrite   = 1'b1;
            PCWrite   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
         end
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            ImmSrc  = op[5] ? IMM_S : IMM_I;
         end
         S_MEMREAD:  AdrSrc = 1'b1;
         S_MEMWB: begin
            ResultSrc = RES_DATA;
            RegWrite  = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
         end
         S_EXECUTER: begin
            ALUSrcA = SRCA_RS1;
            alu_op  = ALUOP_FUNCT;
         end
         S_EXECUTEI: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            alu_op  = ALUOP_FUNCT;
         end
         S_ALUWB:    RegWrite = 1'b1;
         S_BEQ: begin
            ALUSrcA = SRCA_RS1;
            ImmSrc  = IMM_B;
            alu_op  = ALUOP_SUB;
            PCWrite = branch_take;
         end
         S_JAL: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_FOUR;
            ImmSrc  = IMM_J;
            PCWrite = 1'b1;
         end
         S_HALT:     illegal = 1'b1;
         default: ;
      endcase
      // Reset gates every side effect, including the one-cycle window before the state register clears.
      if (reset) begin
         PCWrite  = 1'b0;
         IRWrite  = 1'b0;
         MemWrite = 1'b0;
         RegWrite = 1'b0;
         illegal  = 1'b0;
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_mc_control_g7.sv
// Self-checking bench for mc_control_g7: instruction vectors with per-cycle expected
// outputs pushed to a scoreboard, plus hand-written reset sequences.
module tb_mc_control_g7;
   import mc_control_g7_pkg::*;

   typedef struct packed {
      logic [3:0] st;
      logic [3:0] en;      // {PCWrite, MemWrite, IRWrite, RegWrite}
      logic [3:0] alu;
      logic       ill;
      logic       adr;
      logic [1:0] res;
      logic [1:0] srca;
      logic [1:0] srcb;
      logic [1:0] imm;
   } obs_t;

   typedef struct {
      string          name;
      logic [6:0]     op;
      logic [2:0]     f3;
      logic           f7;
      logic           z;
      logic [3:0]     alu;
      int             n;
      bit [5:0][3:0]  seq;
      bit             nop_dut;
      bit             rst_after;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;

   logic       pcw_h, adr_h, mw_h, irw_h, rw_h, ill_h;
   logic [1:0] res_h, sa_h, sb_h, imm_h;
   logic [3:0] alu_h, st_h;
   logic       pcw_n, adr_n, mw_n, irw_n, rw_n, ill_n;
   logic [1:0] res_n, sa_n, sb_n, imm_n;
   logic [3:0] alu_n, st_n;

   obs_t obs_h, obs_n;
   obs_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   mc_control_g7 #(.ILLEGAL_HALT(1'b1)) dut_h (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
      .PCWrite(pcw_h), .AdrSrc(adr_h), .MemWrite(mw_h), .IRWrite(irw_h), .ResultSrc(res_h),
      .ALUSrcA(sa_h), .ALUSrcB(sb_h), .ImmSrc(imm_h), .RegWrite(rw_h), .ALUControl(alu_h),
      .illegal(ill_h), .state_o(st_h)
   );

   mc_control_g7 #(.ILLEGAL_HALT(1'b0)) dut_n (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
      .PCWrite(pcw_n), .AdrSrc(adr_n), .MemWrite(mw_n), .IRWrite(irw_n), .ResultSrc(res_n),
      .ALUSrcA(sa_n), .ALUSrcB(sb_n), .ImmSrc(imm_n), .RegWrite(rw_n), .ALUControl(alu_n),
      .illegal(ill_n), .state_o(st_n)
   );

   assign obs_h = {st_h, pcw_h, mw_h, irw_h, rw_h, alu_h, ill_h, adr_h, res_h, sa_h, sb_h, imm_h};
   assign obs_n = {st_n, pcw_n, mw_n, irw_n, rw_n, alu_n, ill_n, adr_n, res_n, sa_n, sb_n, imm_n};

   function automatic bit [5:0][3:0] mkseq(input int a, input int b, input int c,
                                           input int d, input int e, input int f);
      bit [5:0][3:0] s;
      s[0] = 4'(a); s[1] = 4'(b); s[2] = 4'(c);
      s[3] = 4'(d); s[4] = 4'(e); s[5] = 4'(f);
      return s;
   endfunction

   function automatic vec_t mkv(input string name, input logic [6:0] o, input logic [2:0] f3,
                                input logic f7, input logic z, input logic [3:0] alu, input int n,
                                input bit [5:0][3:0] seq, input bit nop_dut, input bit rst_after);
      vec_t v;
      v.name = name; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.alu = alu;
      v.n = n; v.seq = seq; v.nop_dut = nop_dut; v.rst_after = rst_after;
      return v;
   endfunction

   // Expected outputs for one cycle, straight from the per-state output table.
   function automatic obs_t mk_exp(input logic [3:0] s, input vec_t v);
      obs_t e;
      logic take;
      e = '0;
      e.st  = s;
      e.alu = ALU_ADD;
      take  = v.f3[0] ? ~v.z : v.z;
      case (s)
         4'd0:  begin e.en = 4'b1010; e.res = 2'b10; e.srcb = 2'b10; end
         4'd1:  begin e.srca = 2'b01; e.srcb = 2'b01; end
         4'd2:  begin e.srca = 2'b10; e.srcb = 2'b01; e.imm = {1'b0, v.op[5]}; end
         4'd3:  e.adr = 1'b1;
         4'd4:  begin e.en = 4'b0001; e.res = 2'b01; end
         4'd5:  begin e.en = 4'b0100; e.adr = 1'b1; end
         4'd6:  begin e.srca = 2'b10; e.alu = v.alu; end
         4'd7:  begin e.srca = 2'b10; e.srcb = 2'b01; e.alu = v.alu; end
         4'd8:  e.en = 4'b0001;
         4'd9:  begin e.en = {take, 3'b000}; e.srca = 2'b10; e.imm = 2'b10; e.alu = ALU_SUB; end
         4'd10: begin e.en = 4'b1000; e.srca = 2'b01; e.srcb = 2'b10; e.imm = 2'b11; end
         4'd11: e.ill = 1'b1;
         default: ;
      endcase
      return e;
   endfunction

   task automatic check(input string nm, input int cyc, input obs_t a, input obs_t e, input obs_t mask);
      n_checks++;
      if ((a & mask) !== (e & mask)) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got st=%0d en=%b alu=%h ill=%b mux=%b, expected st=%0d en=%b alu=%h ill=%b mux=%b (mask %h)",
                  nm, cyc, a.st, a.en, a.alu, a.ill, {a.adr, a.res, a.srca, a.srcb, a.imm},
                  e.st, e.en, e.alu, e.ill, {e.adr, e.res, e.srca, e.srcb, e.imm}, mask);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Called one time unit after a rising edge with both FSMs in FETCH.
   task automatic run_vec(input vec_t v);
      obs_t       e, a;
      logic [3:0] s;
      op = v.op; funct3 = v.f3; funct7b5 = v.f7; zero = v.z;
      for (int i = 0; i < v.n; i++) begin
         s = (i < 6) ? v.seq[i] : v.seq[5];
         sb.push_back(mk_exp(s, v));
      end
      for (int i = 0; i < v.n; i++) begin
         @(negedge clk);
         a = v.nop_dut ? obs_n : obs_h;
         e = sb.pop_front();
         check(v.name, i, a, e, '1);
         @(posedge clk);
         #1;
      end
      if (v.rst_after) do_reset();
   endtask

   obs_t em, mk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; op = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0;

      vecs.push_back(mkv("add",    OP_R,  3'b000, 1'b0, 1'b0, ALU_ADD, 4, mkseq(0,1,6,8,0,0), 1'b0, 1'b0));
      vecs.push_back(mkv("sub",    OP_R,  3'b000, 1'b1, 1'b0, ALU_SUB, 4, mkseq(0,1,6,8,0,0), 1'b0, 1'b0));
      vecs.push_back(mkv("and",    OP_R,  3'b111, 1'b0, 1'b0, ALU_AND, 4, mkseq(0,1,6,8,0,0), 1'b0, 1'b0));
      vecs.push_back(mkv("or",     OP_R,  3'b110, 1'b0, 1'b0, ALU_OR,  4, mkseq(0,1,6,8,0,0), 1'b0, 1'b0));
      vecs.push_back(mkv("addi7",  OP_I,  3'b000, 1'b1, 1'b0, ALU_ADD, 4, mkseq(0,1,7,8,0,0), 1'b0, 1'b0));
      vecs.push_back(mkv("srli",   OP_I,  3'b101, 1'b0, 1'b0, ALU_SRL, 4, mkseq(0,1,7,8,0,0), 1'b0, 1'b0));
      vecs.push_back(mkv("lw",     OP_LW, 3'b010, 1'b0, 1'b0, ALU_ADD, 5, mkseq(0,1,2,3,4,0), 1'b0, 1'b0));
      vecs.push_back(mkv("sw",     OP_SW, 3'b010, 1'b0, 1'b0, ALU_ADD, 4, mkseq(0,1,2,5,0,0), 1'b0, 1'b0));
      vecs.push_back(mkv("beq_z1", OP_BR, 3'b000, 1'b0, 1'b1, ALU_ADD, 3, mkseq(0,1,9,0,0,0), 1'b0, 1'b0));
      vecs.push_back(mkv("beq_z0", OP_BR, 3'b000, 1'b0, 1'b0, ALU_ADD, 3, mkseq(0,1,9,0,0,0), 1'b0, 1'b0));
      vecs.push_back(mkv("jal",    OP_JAL,3'b000, 1'b0, 1'b0, ALU_ADD, 4, mkseq(0,1,10,8,0,0), 1'b0, 1'b0));
`ifdef G7_BNE_EN
      vecs.push_back(mkv("bne_z0", OP_BR, 3'b001, 1'b0, 1'b0, ALU_ADD, 3, mkseq(0,1,9,0,0,0), 1'b0, 1'b0));
      vecs.push_back(mkv("bne_z1", OP_BR, 3'b001, 1'b0, 1'b1, ALU_ADD, 3, mkseq(0,1,9,0,0,0), 1'b0, 1'b0));
`else
      vecs.push_back(mkv("bne_ill",OP_BR, 3'b001, 1'b0, 1'b0, ALU_ADD, 4, mkseq(0,1,11,11,11,11), 1'b0, 1'b1));
`endif
      vecs.push_back(mkv("srai_ill",OP_I, 3'b101, 1'b1, 1'b0, ALU_ADD, 4, mkseq(0,1,11,11,11,11), 1'b0, 1'b1));
      vecs.push_back(mkv("r001_ill",OP_R, 3'b001, 1'b0, 1'b0, ALU_ADD, 4, mkseq(0,1,11,11,11,11), 1'b0, 1'b1));
      vecs.push_back(mkv("lwf3_ill",OP_LW,3'b000, 1'b0, 1'b0, ALU_ADD, 4, mkseq(0,1,11,11,11,11), 1'b0, 1'b1));
      vecs.push_back(mkv("nop_ff",  7'b1111111, 3'b000, 1'b0, 1'b0, ALU_ADD, 3, mkseq(0,1,0,0,0,0), 1'b1, 1'b1));
      vecs.push_back(mkv("nop_swf3",OP_SW,3'b011, 1'b0, 1'b0, ALU_ADD, 3, mkseq(0,1,0,0,0,0), 1'b1, 1'b1));

      // Reset state while reset is held.
      repeat (2) @(posedge clk);
      @(negedge clk);
      em = '0; em.alu = ALU_ADD; em.res = 2'b10; em.srcb = 2'b10;
      check("reset_hold", 0, obs_h, em, '1);
      @(posedge clk);
      #1 reset = 1'b0;

      foreach (vecs[k]) run_vec(vecs[k]);

      // Reset held three cycles in the middle of an lw.
      op = OP_LW; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      reset = 1'b1;
      em = '0; mk = '0; mk.en = '1; mk.ill = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("lw_reset_en", k, obs_h, em, mk);
         if (k > 0) check("lw_reset_st", k, obs_h, em, obs_t'({4'hf, 18'h0}));
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      run_vec(vecs[6]);

      // Reset arriving while MemWrite would be asserted.
      op = OP_SW; funct3 = 3'b010;
      repeat (3) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(negedge clk);
      em = '0; em.st = 4'd5; mk = '0; mk.st = '1; mk.en = '1;
      check("sw_reset_gate", 0, obs_h, em, mk);
      @(posedge clk);
      #1 reset = 1'b0;
      run_vec(vecs[0]);

      // Sticky HALT for more than ten cycles, illegal gated by reset.
      run_vec(mkv("halt_ff", 7'b1111111, 3'b000, 1'b0, 1'b0, ALU_ADD, 13,
                  mkseq(0,1,11,11,11,11), 1'b0, 1'b0));
      reset = 1'b1;
      @(negedge clk);
      em = '0; em.st = 4'd11; mk = '0; mk.st = '1; mk.ill = 1'b1;
      check("halt_reset_gate", 0, obs_h, em, mk);
      @(posedge clk);
      #1 reset = 1'b0;
      run_vec(vecs[10]);

      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
